mem_access: RTL and testbench

//  MEM-stage consumer of the EX/MEM pipeline register outputs. Passes ALU results through to MEM/WB.

---
 rtl/mem_access_pkg.sv | 54 +++++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_access.sv | 172 +++++++++++++++++
 tb/tb_mem_access.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: AluOp load/store codes, bus widths,
// FSM state encodings and small op-decode helpers.
package mem_access_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 8;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;

    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = 8'b0000_0000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 8'b0010_0000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LB  = 8'b1110_0000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LH  = 8'b1110_0001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LW  = 8'b1110_0011;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LBU = 8'b1110_0100;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LHU = 8'b1110_0101;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SB  = 8'b1110_1000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SH  = 8'b1110_1001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } memState_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } accessSize_t;

    function automatic logic isLoad(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_OP_LB) || (op == ALU_OP_LBU) || (op == ALU_OP_LH) ||
               (op == ALU_OP_LHU) || (op == ALU_OP_LW);
    endfunction

    function automatic logic isStore(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_OP_SB) || (op == ALU_OP_SH) || (op == ALU_OP_SW);
    endfunction

    function automatic accessSize_t accessSize(input logic [ALU_OP_W-1:0] op);
        case (op)
            ALU_OP_LB, ALU_OP_LBU, ALU_OP_SB: return SZ_BYTE;
            ALU_OP_LH, ALU_OP_LHU, ALU_OP_SH: return SZ_HALF;
            ALU_OP_LW, ALU_OP_SW:             return SZ_WORD;
            default:                          return SZ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: byte enables and replicated store lanes on the
// way out, lane extraction plus sign/zero extension on the way back.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [ALU_OP_W-1:0]  i_aluop,
    input  logic [1:0]           i_addrLow,
    input  logic [REG_BUS_W-1:0] i_storeData,
    input  logic [REG_BUS_W-1:0] i_loadData,
    output logic [3:0]           o_sel,
    output logic [REG_BUS_W-1:0] o_storeLanes,
    output logic [REG_BUS_W-1:0] o_loadResult
);

    accessSize_t w_size;
    logic        w_zeroExt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane 0 of the address (addr[1:0] = 00) is the most significant byte.
    always_comb begin
        w_size    = accessSize(i_aluop);
        w_zeroExt = (i_aluop == ALU_OP_LBU) || (i_aluop == ALU_OP_LHU);

        case (i_addrLow)
            2'b00:   w_byte = i_loadData[31:24];
            2'b01:   w_byte = i_loadData[23:16];
            2'b10:   w_byte = i_loadData[15:8];
            default: w_byte = i_loadData[7:0];
        endcase
        w_half = i_addrLow[1] ? i_loadData[15:0] : i_loadData[31:16];

        o_sel        = 4'b0000;
        o_storeLanes = ZERO_WORD;
        o_loadResult = ZERO_WORD;
        case (w_size)
            SZ_BYTE: begin
                o_sel        = 4'b1000 >> i_addrLow;
                o_storeLanes = {4{i_storeData[7:0]}};
                o_loadResult = w_zeroExt ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_sel        = i_addrLow[1] ? 4'b0011 : 4'b1100;
                o_storeLanes = {2{i_storeData[15:0]}};
                o_loadResult = w_zeroExt ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_sel        = 4'b1111;
                o_storeLanes = i_storeData;
                o_loadResult = i_loadData;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: passes ALU results to MEM/WB and runs loads/stores as req/ack bus
// transactions, stalling the pipeline meanwhile. Optional MEM_ALIGN_CHECK_EN
// rejects misaligned accesses and adds the misalign_o port.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] mem_wd_i,
    input  logic                  mem_wreg_i,
    input  logic [REG_BUS_W-1:0]  mem_wdata_i,
    input  logic [ALU_OP_W-1:0]   mem_aluop_i,
    input  logic [REG_BUS_W-1:0]  mem_addr_i,
    input  logic [REG_BUS_W-1:0]  mem_reg2_i,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [REG_BUS_W-1:0]  dbus_addr,
    output logic [3:0]            dbus_sel,
    output logic [REG_BUS_W-1:0]  dbus_wdata,
    input  logic                  dbus_ack,
    input  logic [REG_BUS_W-1:0]  dbus_rdata,
    output logic [REG_ADDR_W-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [REG_BUS_W-1:0]  wb_wdata,
    output logic                  stallreq,
    output logic                  bus_err
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                  misalign_o
`endif
);

    localparam logic [TO_W-1:0] TIMEOUT_LIMIT = TO_W'(BUS_TIMEOUT);

    memState_t             r_state;
    logic                  r_dbusReq;
    logic                  r_dbusWe;
    logic [REG_BUS_W-1:0]  r_dbusAddr;
    logic [3:0]            r_dbusSel;
    logic [REG_BUS_W-1:0]  r_dbusWdata;
    logic [REG_BUS_W-1:0]  r_rdataQ;
    logic                  r_errQ;
    logic [TO_W-1:0]       r_count;

    logic                  w_isLoad;
    logic                  w_memOp;
    logic                  w_misalign;
    logic [3:0]            w_sel;
    logic [REG_BUS_W-1:0]  w_storeLanes;
    logic [REG_BUS_W-1:0]  w_loadResult;
    logic [TO_W-1:0]       w_countNext;
    logic                  w_timeout;

    assign w_isLoad    = isLoad(mem_aluop_i);
    assign w_memOp     = w_isLoad || isStore(mem_aluop_i);
    assign w_countNext = r_count + TO_W'(1);
    assign w_timeout   = (BUS_TIMEOUT != 0) && (w_countNext == TIMEOUT_LIMIT);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ((accessSize(mem_aluop_i) == SZ_HALF) && mem_addr_i[0]) ||
                        ((accessSize(mem_aluop_i) == SZ_WORD) && (mem_addr_i[1:0] != 2'b00));
    assign misalign_o = !rst && (r_state == ST_IDLE) && w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    // Load data comes from the captured bus word, so the load path is only
    // meaningful in DONE; store lanes are used when the request is launched.
    mem_lane_align u_laneAlign (
        .i_aluop      (mem_aluop_i),
        .i_addrLow    (mem_addr_i[1:0]),
        .i_storeData  (mem_reg2_i),
        .i_loadData   (r_rdataQ),
        .o_sel        (w_sel),
        .o_storeLanes (w_storeLanes),
        .o_loadResult (w_loadResult)
    );

    assign dbus_req   = r_dbusReq;
    assign dbus_we    = r_dbusWe;
    assign dbus_addr  = r_dbusAddr;
    assign dbus_sel   = r_dbusSel;
    assign dbus_wdata = r_dbusWdata;

    // Transaction FSM; ack takes priority over a timeout landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dbusReq   <= 1'b0;
            r_dbusWe    <= 1'b0;
            r_dbusAddr  <= ZERO_WORD;
            r_dbusSel   <= 4'b0000;
            r_dbusWdata <= ZERO_WORD;
            r_rdataQ    <= ZERO_WORD;
            r_errQ      <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_count <= '0;
                    r_errQ  <= 1'b0;
                    if (w_memOp && !w_misalign) begin
                        r_state     <= ST_REQ;
                        r_dbusReq   <= 1'b1;
                        r_dbusWe    <= !w_isLoad;
                        r_dbusAddr  <= {mem_addr_i[REG_BUS_W-1:2], 2'b00};
                        r_dbusSel   <= w_sel;
                        r_dbusWdata <= w_storeLanes;
                    end
                end
                ST_REQ: begin
                    if (dbus_ack) begin
                        r_rdataQ  <= dbus_rdata;
                        r_dbusReq <= 1'b0;
                        r_dbusWe  <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (w_timeout) begin
                        r_dbusReq <= 1'b0;
                        r_dbusWe  <= 1'b0;
                        r_errQ    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_count <= w_countNext;
                    end
                end
                ST_DONE: begin
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // MEM/WB and stall outputs; reset overrides everything so the pipeline
    // sees a NOP while rst is high.
    always_comb begin
        wb_wd    = mem_wd_i;
        wb_wreg  = 1'b0;
        wb_wdata = ZERO_WORD;
        stallreq = 1'b0;
        bus_err  = 1'b0;
        if (rst) begin
            wb_wd = NOP_REG_ADDR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_memOp) begin
                        wb_wreg  = mem_wreg_i;
                        wb_wdata = mem_wdata_i;
                    end else if (!w_misalign) begin
                        stallreq = 1'b1;
                    end
                end
                ST_REQ: stallreq = 1'b1;
                ST_DONE: begin
                    if (r_errQ) begin
                        bus_err = 1'b1;
                    end else if (w_isLoad) begin
                        wb_wreg  = mem_wreg_i;
                        wb_wdata = w_loadResult;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (BUS_TIMEOUT = 4); the misalign
// scenario is built only when MEM_ALIGN_CHECK_EN is defined.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  memWd;
    logic        memWreg;
    logic [31:0] memWdata;
    logic [7:0]  memAluop;
    logic [31:0] memAddr;
    logic [31:0] memReg2;
    logic        dbusReq;
    logic        dbusWe;
    logic [31:0] dbusAddr;
    logic [3:0]  dbusSel;
    logic [31:0] dbusWdata;
    logic        dbusAck;
    logic [31:0] dbusRdata;
    logic [4:0]  wbWd;
    logic        wbWreg;
    logic [31:0] wbWdata;
    logic        stallReq;
    logic        busErr;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int vecCount  = 0;
    int missCount = 0;

    mem_access #(.BUS_TIMEOUT(4), .TO_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_wd_i    (memWd),
        .mem_wreg_i  (memWreg),
        .mem_wdata_i (memWdata),
        .mem_aluop_i (memAluop),
        .mem_addr_i  (memAddr),
        .mem_reg2_i  (memReg2),
        .dbus_req    (dbusReq),
        .dbus_we     (dbusWe),
        .dbus_addr   (dbusAddr),
        .dbus_sel    (dbusSel),
        .dbus_wdata  (dbusWdata),
        .dbus_ack    (dbusAck),
        .dbus_rdata  (dbusRdata),
        .wb_wd       (wbWd),
        .wb_wreg     (wbWreg),
        .wb_wdata    (wbWdata),
        .stallreq    (stallReq),
        .bus_err     (busErr)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign_o  (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveOp(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        memAluop = op;
        memAddr  = addr;
        memReg2  = reg2;
        memWd    = wd;
        memWreg  = wreg;
        memWdata = wdata;
    endtask

    task automatic driveNop();
        driveOp(ALU_OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dbusAck = 1'b0;
        dbusRdata = 32'h0;
        driveOp(ALU_OP_LW, 32'h40, 32'h0, 5'd9, 1'b1, 32'h55);
        step();
        step();
        @(negedge clk);
        vecCount++;
        if ({dbusReq, dbusWe, dbusAddr, dbusSel, dbusWdata} !== 70'h0) begin
            missCount++;
            $display("[TB] FAIL reset_bus: got req=%b we=%b addr=%h sel=%b wdata=%h, expected all 0",
                     dbusReq, dbusWe, dbusAddr, dbusSel, dbusWdata);
        end
        vecCount++;
        if ({wbWd, wbWreg, wbWdata, stallReq, busErr} !== 40'h0) begin
            missCount++;
            $display("[TB] FAIL reset_wb: got wd=%0d wreg=%b wdata=%h stall=%b err=%b, expected all 0",
                     wbWd, wbWreg, wbWdata, stallReq, busErr);
        end
        step();
        rst = 1'b0;
        driveNop();
    endtask

    task automatic test_add();
        logic reqSeen;
        reqSeen = 1'b0;
        driveOp(ALU_OP_ADD, 32'h0, 32'h0, 5'd3, 1'b1, 32'h12345678);
        @(negedge clk);
        vecCount++;
        if ({wbWd, wbWreg, wbWdata} !== {5'd3, 1'b1, 32'h12345678}) begin
            missCount++;
            $display("[TB] FAIL add_wb: got wd=%0d wreg=%b wdata=%h, expected wd=3 wreg=1 wdata=12345678",
                     wbWd, wbWreg, wbWdata);
        end
        vecCount++;
        if (stallReq !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL add_stall: got %b, expected 0", stallReq);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            reqSeen = reqSeen | dbusReq;
        end
        vecCount++;
        if (reqSeen !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL add_noreq: got req seen=%b, expected 0", reqSeen);
        end
        step();
        driveNop();
    endtask

    task automatic test_lb();
        int stallCycles;
        stallCycles = 0;
        driveOp(ALU_OP_LB, 32'h101, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        stallCycles += int'(stallReq);
        vecCount++;
        if (dbusReq !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL lb_idle_req: got %b, expected 0", dbusReq);
        end
        step();
        @(negedge clk);
        stallCycles += int'(stallReq);
        vecCount++;
        if ({dbusReq, dbusWe, dbusSel, dbusAddr} !== {1'b1, 1'b0, 4'b0100, 32'h100}) begin
            missCount++;
            $display("[TB] FAIL lb_req: got req=%b we=%b sel=%b addr=%h, expected 1 0 0100 00000100",
                     dbusReq, dbusWe, dbusSel, dbusAddr);
        end
        step();
        dbusAck = 1'b1;
        dbusRdata = 32'h11AA2233;
        @(negedge clk);
        stallCycles += int'(stallReq);
        step();
        dbusAck = 1'b0;
        dbusRdata = 32'h0;
        @(negedge clk);
        vecCount++;
        if ({wbWd, wbWreg, wbWdata} !== {5'd5, 1'b1, 32'hFFFFFFAA}) begin
            missCount++;
            $display("[TB] FAIL lb_done: got wd=%0d wreg=%b wdata=%h, expected 5 1 FFFFFFAA",
                     wbWd, wbWreg, wbWdata);
        end
        vecCount++;
        if ({stallReq, dbusReq} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL lb_done_stall: got stall=%b req=%b, expected 0 0", stallReq, dbusReq);
        end
        vecCount++;
        if (stallCycles != 3) begin
            missCount++;
            $display("[TB] FAIL lb_stall_len: got %0d cycles, expected 3", stallCycles);
        end
        step();
        driveNop();
    endtask

    task automatic test_store();
        logic [7:0]  ops   [3];
        logic [31:0] addrs [3];
        logic [31:0] reg2s [3];
        logic [3:0]  sels  [3];
        logic [31:0] lanes [3];
        logic [31:0] words [3];
        ops   = '{ALU_OP_SH, ALU_OP_SB, ALU_OP_SW};
        addrs = '{32'h202, 32'h803, 32'h900};
        reg2s = '{32'h0000BEEF, 32'h000000A5, 32'hDEADBEEF};
        sels  = '{4'b0011, 4'b0001, 4'b1111};
        lanes = '{32'hBEEFBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
        words = '{32'h200, 32'h800, 32'h900};
        for (int i = 0; i < 3; i++) begin
            driveOp(ops[i], addrs[i], reg2s[i], 5'd7, 1'b1, 32'h1111);
            @(negedge clk);
            step();
            dbusAck = 1'b1;
            @(negedge clk);
            vecCount++;
            if ({dbusReq, dbusWe, dbusSel, dbusAddr, dbusWdata} !== {1'b1, 1'b1, sels[i], words[i], lanes[i]}) begin
                missCount++;
                $display("[TB] FAIL store%0d_req: got req=%b we=%b sel=%b addr=%h wdata=%h, expected 1 1 %b %h %h",
                         i, dbusReq, dbusWe, dbusSel, dbusAddr, dbusWdata, sels[i], words[i], lanes[i]);
            end
            step();
            dbusAck = 1'b0;
            @(negedge clk);
            vecCount++;
            if ({wbWreg, wbWdata, stallReq} !== 34'h0) begin
                missCount++;
                $display("[TB] FAIL store%0d_done: got wreg=%b wdata=%h stall=%b, expected 0 0 0",
                         i, wbWreg, wbWdata, stallReq);
            end
            step();
        end
        driveNop();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ops   [5];
        logic [31:0] addrs [5];
        logic [31:0] rdats [5];
        logic [3:0]  sels  [5];
        logic [31:0] exps  [5];
        ops   = '{ALU_OP_LW, ALU_OP_LHU, ALU_OP_LH, ALU_OP_LBU, ALU_OP_LB};
        addrs = '{32'h600, 32'h602, 32'h600, 32'h603, 32'h600};
        rdats = '{32'hCAFEF00D, 32'h1234ABCD, 32'h8001ABCD, 32'h000000F0, 32'h7F000000};
        sels  = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b1000};
        exps  = '{32'hCAFEF00D, 32'h0000ABCD, 32'hFFFF8001, 32'h000000F0, 32'h0000007F};
        for (int i = 0; i < 5; i++) begin
            driveOp(ops[i], addrs[i], 32'h0, 5'd10, 1'b1, 32'h0);
            @(negedge clk);
            vecCount++;
            if ({stallReq, dbusReq} !== 2'b10) begin
                missCount++;
                $display("[TB] FAIL b2b%0d_idle: got stall=%b req=%b, expected 1 0", i, stallReq, dbusReq);
            end
            step();
            dbusAck = 1'b1;
            dbusRdata = rdats[i];
            @(negedge clk);
            vecCount++;
            if ({dbusReq, dbusSel, dbusAddr} !== {1'b1, sels[i], 32'h600}) begin
                missCount++;
                $display("[TB] FAIL b2b%0d_req: got req=%b sel=%b addr=%h, expected 1 %b 00000600",
                         i, dbusReq, dbusSel, dbusAddr, sels[i]);
            end
            step();
            dbusAck = 1'b0;
            dbusRdata = 32'h0;
            @(negedge clk);
            vecCount++;
            if ({wbWreg, wbWdata, stallReq} !== {1'b1, exps[i], 1'b0}) begin
                missCount++;
                $display("[TB] FAIL b2b%0d_done: got wreg=%b wdata=%h stall=%b, expected 1 %h 0",
                         i, wbWreg, wbWdata, stallReq, exps[i]);
            end
            step();
        end
        driveNop();
    endtask

    task automatic test_timeout();
        int reqCycles;
        reqCycles = 0;
        driveOp(ALU_OP_LW, 32'h400, 32'h0, 5'd4, 1'b1, 32'h0);
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            step();
            @(negedge clk);
            if (dbusReq) reqCycles++;
            else break;
        end
        vecCount++;
        if (reqCycles != 4) begin
            missCount++;
            $display("[TB] FAIL timeout_len: got %0d req cycles, expected 4", reqCycles);
        end
        vecCount++;
        if ({busErr, wbWreg, stallReq} !== 3'b100) begin
            missCount++;
            $display("[TB] FAIL timeout_done: got err=%b wreg=%b stall=%b, expected 1 0 0",
                     busErr, wbWreg, stallReq);
        end
        step();
        driveNop();
        @(negedge clk);
        vecCount++;
        if (busErr !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL timeout_pulse: got err=%b after DONE, expected 0", busErr);
        end
        step();
    endtask

    task automatic test_reset_mid_req();
        driveOp(ALU_OP_LW, 32'h500, 32'h0, 5'd6, 1'b1, 32'h0);
        @(negedge clk);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        vecCount++;
        if (stallReq !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL rstreq_stall: got %b while rst high, expected 0", stallReq);
        end
        step();
        rst = 1'b0;
        driveNop();
        dbusAck = 1'b1;
        dbusRdata = 32'hFFFFFFFF;
        @(negedge clk);
        vecCount++;
        if ({dbusReq, dbusWe, dbusAddr, dbusSel, dbusWdata} !== 70'h0) begin
            missCount++;
            $display("[TB] FAIL rstreq_bus: got req=%b we=%b addr=%h sel=%b wdata=%h, expected all 0",
                     dbusReq, dbusWe, dbusAddr, dbusSel, dbusWdata);
        end
        vecCount++;
        if ({stallReq, busErr, wbWreg} !== 3'b000) begin
            missCount++;
            $display("[TB] FAIL rstreq_wb: got stall=%b err=%b wreg=%b, expected 0 0 0",
                     stallReq, busErr, wbWreg);
        end
        step();
        dbusAck = 1'b0;
        dbusRdata = 32'h0;
        @(negedge clk);
        vecCount++;
        if ({stallReq, busErr, dbusReq} !== 3'b000) begin
            missCount++;
            $display("[TB] FAIL rstreq_ack_ignored: got stall=%b err=%b req=%b, expected 0 0 0",
                     stallReq, busErr, dbusReq);
        end
        step();
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_misalign();
        driveOp(ALU_OP_LW, 32'h302, 32'h0, 5'd2, 1'b1, 32'h0);
        @(negedge clk);
        vecCount++;
        if ({misalign, stallReq, wbWreg, dbusReq} !== 4'b1000) begin
            missCount++;
            $display("[TB] FAIL misalign_hit: got mis=%b stall=%b wreg=%b req=%b, expected 1 0 0 0",
                     misalign, stallReq, wbWreg, dbusReq);
        end
        step();
        driveNop();
        @(negedge clk);
        vecCount++;
        if ({misalign, dbusReq} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL misalign_after: got mis=%b req=%b, expected 0 0", misalign, dbusReq);
        end
        step();
    endtask
`else
    task automatic test_unaligned_ignored();
        driveOp(ALU_OP_LW, 32'h703, 32'h0, 5'd8, 1'b1, 32'h0);
        @(negedge clk);
        step();
        dbusAck = 1'b1;
        dbusRdata = 32'h01020304;
        @(negedge clk);
        vecCount++;
        if ({dbusReq, dbusSel, dbusAddr} !== {1'b1, 4'b1111, 32'h700}) begin
            missCount++;
            $display("[TB] FAIL unaligned_req: got req=%b sel=%b addr=%h, expected 1 1111 00000700",
                     dbusReq, dbusSel, dbusAddr);
        end
        step();
        dbusAck = 1'b0;
        dbusRdata = 32'h0;
        @(negedge clk);
        vecCount++;
        if ({wbWreg, wbWdata} !== {1'b1, 32'h01020304}) begin
            missCount++;
            $display("[TB] FAIL unaligned_done: got wreg=%b wdata=%h, expected 1 01020304", wbWreg, wbWdata);
        end
        step();
        driveNop();
    endtask
`endif

    initial begin
        rst = 1'b1;
        dbusAck = 1'b0;
        dbusRdata = 32'h0;
        driveNop();
        $display("[TB] starting mem_access bench");
        test_reset();
        test_add();
        test_lb();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid_req();
`ifdef MEM_ALIGN_CHECK_EN
        test_misalign();
`else
        test_unaligned_ignored();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
